// File: rtl/sw_score_hub_if.sv
// Channel-side score handshake plus host-side stream FIFO signals for sw_score_hub.
// The master drives channel scores and host read/open strobes; the hub is the slave.
interface sw_score_hub_if #(
   parameter int NUM_CH  = 4,
   parameter int SCORE_W = 16
);
   logic [NUM_CH-1:0]         ch_valid;
   logic [NUM_CH*SCORE_W-1:0] ch_score;
   logic [NUM_CH-1:0]         ch_last;
   logic [NUM_CH-1:0]         ch_ready;
   logic                      user_r_stream_score_out_rden;
   logic                      user_r_stream_score_out_empty;
   logic [31:0]               user_r_stream_score_out_data;
   logic                      user_r_stream_score_out_eof;
   logic                      user_r_stream_score_out_open;

   modport master (
      output ch_valid, ch_score, ch_last,
      output user_r_stream_score_out_rden, user_r_stream_score_out_open,
      input  ch_ready,
      input  user_r_stream_score_out_empty, user_r_stream_score_out_data,
      input  user_r_stream_score_out_eof
   );

   modport slave (
      input  ch_valid, ch_score, ch_last,
      input  user_r_stream_score_out_rden, user_r_stream_score_out_open,
      output ch_ready,
      output user_r_stream_score_out_empty, user_r_stream_score_out_data,
      output user_r_stream_score_out_eof
   );
endinterface

// File: rtl/sw_score_hub.sv
// Round-robin merge of NUM_CH score channels into a 32-bit host read FIFO with end-of-stream.
// Optional macro SW_SCORE_HUB_COUNT_EN adds a trailer word carrying the accepted-score count.
module sw_score_hub #(
   parameter int NUM_CH  = 4,
   parameter int SCORE_W = 16,
   parameter int DEPTH   = 16
) (
   input  logic          clk,
   input  logic          rst,
   sw_score_hub_if.slave bus
);
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;

`ifdef SW_SCORE_HUB_COUNT_EN
   typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_TRAILER, S_EOF} state_t;
`else
   typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_EOF} state_t;
`endif

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_CH-1:0]  done_q, done_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      fill_q, fill_d;
   logic [31:0]        data_q, data_d;
   logic               open_q, open_d;
   logic [31:0]        mem_q [DEPTH];

   logic               flush, full, empty, gnt_vld, accept, push, pop;
   logic [PTR_W:0]     pick;
   logic [PTR_W-1:0]   gnt_idx;
   logic [NUM_CH-1:0]  gnt_onehot;
   logic [SCORE_W-1:0] gnt_score;
   logic [31:0]        push_word;

`ifdef SW_SCORE_HUB_COUNT_EN
   logic [23:0]        cnt_q, cnt_d;

   function automatic logic [23:0] sat_inc(input logic [23:0] v);
      return (v == 24'hFFFFFF) ? v : v + 24'd1;
   endfunction
`endif

   // First eligible channel at or after ptr (mod NUM_CH); MSB of the result flags a grant.
   function automatic logic [PTR_W:0] rr_pick(input logic [PTR_W-1:0] ptr,
                                              input logic [NUM_CH-1:0] elig);
      logic [PTR_W:0] res;
      int             idx;
      res = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_CH;
         if (elig[idx]) res = {1'b1, PTR_W'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      flush      = open_q & ~bus.user_r_stream_score_out_open;
      full       = (fill_q == CW'(DEPTH));
      empty      = (fill_q == '0);
      pick       = rr_pick(ptr_q, bus.ch_valid & ~done_q);
      gnt_vld    = pick[PTR_W];
      gnt_idx    = pick[PTR_W-1:0];
      accept     = gnt_vld & ~full & ~flush & ~rst & (state_q == S_COLLECT);
      gnt_onehot = '0;
      gnt_onehot[gnt_idx] = 1'b1;
      gnt_score  = bus.ch_score[int'(gnt_idx)*SCORE_W +: SCORE_W];
      push_word  = {bus.ch_last[gnt_idx], 3'(gnt_idx), 4'h0, 24'(gnt_score)};
      push       = accept;
`ifdef SW_SCORE_HUB_COUNT_EN
      cnt_d      = accept ? sat_inc(cnt_q) : cnt_q;
      if ((state_q == S_TRAILER) && !full && !flush) begin
         push      = 1'b1;
         push_word = {1'b1, 3'b000, 4'hF, cnt_q};
      end
`endif
      pop        = bus.user_r_stream_score_out_rden & ~empty & ~flush;

      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      fill_d     = fill_q + CW'(push) - CW'(pop);
      data_d     = pop ? mem_q[rd_ptr_q] : data_q;
      done_d     = done_q | ((accept & bus.ch_last[gnt_idx]) ? gnt_onehot : '0);
      ptr_d      = accept ? PTR_W'((int'(gnt_idx) + 1) % NUM_CH) : ptr_q;
      open_d     = bus.user_r_stream_score_out_open;

      state_d = state_q;
      unique case (state_q)
         S_COLLECT: if (&done_q) state_d = S_DRAIN;
`ifdef SW_SCORE_HUB_COUNT_EN
         S_DRAIN:   if (empty) state_d = S_TRAILER;
         S_TRAILER: state_d = S_EOF;
`else
         S_DRAIN:   if (empty) state_d = S_EOF;
`endif
         S_EOF:     state_d = S_EOF;
         default:   state_d = S_COLLECT;
      endcase

      // Host closing the file behaves like a reset of the stream.
      if (flush) begin
         state_d  = S_COLLECT;
         ptr_d    = '0;
         done_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
         data_d   = '0;
`ifdef SW_SCORE_HUB_COUNT_EN
         cnt_d    = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_COLLECT;
         ptr_q    <= '0;
         done_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         data_q   <= '0;
         open_q   <= 1'b0;
`ifdef SW_SCORE_HUB_COUNT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         data_q   <= data_d;
         open_q   <= open_d;
`ifdef SW_SCORE_HUB_COUNT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_word;
   end

   assign bus.ch_ready                      = accept ? gnt_onehot : '0;
   assign bus.user_r_stream_score_out_empty = empty;
   assign bus.user_r_stream_score_out_data  = data_q;
   assign bus.user_r_stream_score_out_eof   = (state_q == S_EOF) & empty;
endmodule

// File: doc/sw_score_hub.md
SW_SCORE_HUB -- requirements
Module: sw_score_hub

Interface
REQ-001 Parameter NUM_CH, default 4, sets the number of score-producing channels (1..8) that SHALL be merged.
REQ-002 Parameter SCORE_W, default 16, sets the per-channel score width in bits (8..24).
REQ-003 Parameter DEPTH, default 16, sets the output FIFO depth in 32-bit words (power of 2, 4..256).
REQ-004 clk  in  1  single clock (bus clock); all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset (driven from quiesce).
REQ-006 ch_valid  in  NUM_CH  per-channel score valid.
REQ-007 ch_score  in  NUM_CH*SCORE_W  flattened scores; channel i occupies bits [i*SCORE_W +: SCORE_W].
REQ-008 ch_last  in  NUM_CH  qualifies ch_score as that channel's final score.
REQ-009 ch_ready  out  NUM_CH  per-channel accept; a transfer occurs when ch_valid[i] & ch_ready[i].
REQ-010 user_r_stream_score_out_rden  in  1  host read strobe.
REQ-011 user_r_stream_score_out_empty  out  1  FIFO empty.
REQ-012 user_r_stream_score_out_data  out  32  read word.
REQ-013 user_r_stream_score_out_eof  out  1  end of stream.
REQ-014 user_r_stream_score_out_open  in  1  host has the device file open.

Function
REQ-015 Word format SHALL be: bit31 = ch_last, bits30:28 = channel index, bits27:24 = 0, bits23:0 = score zero-extended.
REQ-016 The round-robin arbiter SHALL grant at most one channel per cycle, searching from pointer ptr upward modulo NUM_CH; after a grant, ptr SHALL become (granted+1) mod NUM_CH.
REQ-017 ch_ready[i] SHALL be combinational and high only for the granted channel, only when the FIFO holds fewer than DEPTH words, and only if channel i has not yet delivered its last score.
REQ-018 A write SHALL be refused when the FIFO is full, even if rden is asserted in the same cycle.
REQ-019 An accepted word SHALL deassert empty on the following cycle (one-cycle write-to-empty latency).
REQ-020 Reads SHALL follow standard-FIFO semantics: the word appears on data in the cycle after rden & !empty; rden while empty SHALL be ignored.
REQ-021 A per-channel done flag SHALL be set when that channel's last score is accepted.
REQ-022 The FSM SHALL have states COLLECT, DRAIN, TRAILER and EOF; COLLECT->DRAIN when all NUM_CH done flags are set.
REQ-023 DRAIN->TRAILER (when SW_SCORE_HUB_COUNT_EN is defined) or DRAIN->EOF (when it is not) SHALL occur when the FIFO is empty; TRAILER->EOF after one cycle.
REQ-024 In EOF, eof SHALL be high while empty is high; EOF SHALL persist until rst or an open falling edge.
REQ-025 An open 1->0 transition SHALL flush the FIFO, clear done flags and the count, set ptr to 0 and return to COLLECT, exactly as rst does.
REQ-026 The accepted-score counter SHALL be 24 bits wide and saturate at 24'hFFFFFF.

Reset
REQ-027 On rst: FIFO empty (empty=1), data=0, eof=0, ch_ready=0 for one cycle, ptr=0, done flags=0, count=0, state COLLECT.
REQ-028 A reset asserted mid-transfer SHALL discard all buffered words; the host SHALL see no partial word.

Configuration
REQ-029 With macro SW_SCORE_HUB_COUNT_EN defined, the TRAILER state SHALL push one word {1'b1, 3'b000, 4'hF, count[23:0]} before EOF.
REQ-030 Without SW_SCORE_HUB_COUNT_EN, the TRAILER state and the counter SHALL be absent, and DRAIN SHALL go directly to EOF.

Verification
REQ-031 NUM_CH=4, all channels valid with scores 0x10..0x13, none last -> words read in order ch0,ch1,ch2,ch3 = 0x00000010, 0x10000011, 0x20000012, 0x30000013.
REQ-032 DEPTH=4, ch0 continuously valid, no rden -> exactly 4 words accepted; ch_ready[0]=0 while full; a single rden re-enables exactly one accept.
REQ-033 Each channel sends 2 scores, the second with last=1, host drains -> 8 words, four with bit31=1; with COUNT_EN, a 9th word 0x8F000008 is read, then eof=1.
REQ-034 After ch2 delivers its last score, ch2 holds valid high -> ch_ready[2] stays 0 and no further ch2 words appear.
REQ-035 open dropped with 3 words buffered -> the next cycle shows empty=1 and eof=0, and the state returns to COLLECT.
